delay_estimator: RTL and testbench
==================================

// Module: delay_estimator
// PURPOSE
//  Receive-side counterpart of the programmable 0..15-cycle delay line. Observes the
//  undelayed stream (ref_i) and the delayed stream (dly_i) and determines the delay
//  by correlation. Reports the delay once unambiguous, then monitors it. Sits beside
//  the delay line for self-test and delay calibration.
// PARAMETERS
//  MAX_DELAY  15  largest delay searched (taps 0..MAX_DELAY)
//  DLY_W      4   width of delay_o; localparam = $clog2(MAX_DELAY+1), not overridable
//  LOCK_CNT   32  compare cycles per acquisition window (>=2)
// PORTS
//  clk_i     in   1      clock, all logic on posedge
//  rst_ni    in   1      asynchronous, active-low reset
//  ref_i     in   1      undelayed data stream
//  dly_i     in   1      delayed data stream
//  start_i   in   1      begin/restart acquisition (1-cycle pulse or level)
//  delay_o   out  DLY_W  measured delay; valid only while valid_o=1
//  valid_o   out  1      locked, delay_o trustworthy
//  busy_o    out  1      acquisition in progress
//  err_o     out  1      no tap consistent with observed data
// BEHAVIOUR
//  Reset: hist=0, cand=all-ones, cnt=0, state IDLE; delay_o/valid_o/busy_o/err_o = 0.
//  Taps: tap[0]=ref_i (same cycle); tap[k]=ref_i delayed k cycles. hist shifts every cycle
//   in every state from reset release.
//  match[k] = (dly_i == tap[k]).
//  FSM IDLE/ACQ/LOCKED/FAIL; outputs registered; state/output visible cycle after cause.
//  IDLE: all outputs 0; start_i -> ACQ (cand=all-ones, cnt=0).
//  ACQ: busy_o=1. Each cycle cand&=match, cnt++.
//   - cand&match==0 -> FAIL (priority over window end).
//   - at cnt==LOCK_CNT-1: exactly one bit set -> LOCKED, delay_o=its index;
//     >1 bit set -> stay ACQ, cnt=0, keep cand (stream not rich enough).
//   - start_i sampled at t -> first compare in cycle t+1. Earliest valid_o=1 in cycle
//     t+LOCK_CNT+1.
//  LOCKED: valid_o=1, delay_o held. Each cycle check match[delay_o].
//   - Mismatch -> see CONFIGURATION.
//  FAIL: err_o=1, delay_o=0; hold until start_i.
//  start_i in ACQ/LOCKED/FAIL: restart ACQ, clear valid_o and err_o next cycle.
//  Reset mid-operation: immediate return to reset values, including mid-window.
//  hist is not cleared on start_i. Taps beyond elapsed time since reset compare
//   against zeros (correct model of a reset delay line).
// CONFIGURATION
//  DELAY_EST_RELOCK_EN defined: mismatch in LOCKED -> ACQ (cand=all-ones, cnt=0, busy_o=1,
//   valid_o=0, err_o stays 0); re-lock with no start_i.
//  Undefined: mismatch in LOCKED -> FAIL (err_o=1, valid_o=0) until start_i.
// STRUCTURE
//  delay_est_pkg: state_e enum {IDLE,ACQ,LOCKED,FAIL}; MAX_DELAY_DEF=15, LOCK_CNT_DEF=32;
//   function onehot_idx() (index of single set bit), function is_onehot().
//  Sub-module delay_tap_line: MAX_DELAY-deep shift register, async active-low reset,
//   exports tap[MAX_DELAY:0] with tap[0]=ref_i.
//  Top: FSM, cand mask, window counter, output registers.
// TESTING (bench drives dly_i from a behavioural delay model; ref_i random unless noted)
//  1. Delay 0, start_i at t -> valid_o=1, delay_o=0 at cycle t+33; busy_o 0 at t+33.
//  2. Delay 15, run 20 cycles after reset, then start_i -> valid_o=1, delay_o=15,
//     err_o=0.
//  3. ref_i held 1, delay 5, start_i -> busy_o=1, valid_o=0 for >=96 cycles; ref_i then
//     random -> locks with delay_o=5.
//  4. dly_i = ~ref delayed 3 -> err_o=1 within LOCK_CNT cycles, valid_o=0; start_i
//     clears err_o.
//  5. Locked at 7, model switched to 3 -> next cycle after first mismatch: err_o=1
//     (no macro); with DELAY_EST_RELOCK_EN: busy_o=1, then valid_o=1, delay_o=3.
//  6. rst_ni low mid-ACQ (cnt~10) and mid-LOCKED -> all outputs 0 asynchronously;
//     start_i after release -> normal lock.

Source files
------------

// File: rtl/delay_est_pkg.sv
// Shared types, defaults and one-hot helpers for the delay estimator.
package delay_est_pkg;

  localparam int MAX_DELAY_DEF = 15;
  localparam int LOCK_CNT_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCKED,
    FAIL
  } state_e;

  // Candidate masks are zero-extended to 32 bits, so MAX_DELAY must stay below 32.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

  function automatic int onehot_idx(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/delay_tap_line.sv
// Model of the reference delay line: tap_o[k] is ref_i delayed by k cycles, tap_o[0] is ref_i itself.
module delay_tap_line
  import delay_est_pkg::*;
#(
  parameter int MAX_DELAY = MAX_DELAY_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ref_i,
  output logic [MAX_DELAY:0]   tap_o
);

  logic [MAX_DELAY-1:0] hist_q;

  // NOTE: the history is reset on purpose, so taps older than the time since reset read as
  // zeros, exactly like the real delay line coming out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
    end else begin
      // NOTE: non-blocking assignment, so every stage shifts from the same pre-edge values.
      hist_q <= MAX_DELAY'({hist_q, ref_i});
    end
  end

  assign tap_o = {hist_q, ref_i};

endmodule

// File: rtl/delay_estimator.sv
// Correlating delay estimator: finds the single tap of ref_i that matches dly_i, then monitors it.
// Build option: define DELAY_EST_RELOCK_EN to re-acquire on loss of lock instead of flagging an error.
module delay_estimator
  import delay_est_pkg::*;
#(
  parameter  int MAX_DELAY = MAX_DELAY_DEF,
  parameter  int LOCK_CNT  = LOCK_CNT_DEF,
  localparam int DLY_W     = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ref_i,
  input  logic             dly_i,
  input  logic             start_i,
  output logic [DLY_W-1:0] delay_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int CNT_W = $clog2(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CNT - 1);

  state_e               state_q, state_d;
  logic [MAX_DELAY:0]   cand_q, cand_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DLY_W-1:0]     delay_q, delay_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic [MAX_DELAY:0]   tap;
  logic [MAX_DELAY:0]   match;
  logic [MAX_DELAY:0]   cand_next;

  delay_tap_line #(.MAX_DELAY(MAX_DELAY)) u_tap_line (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .ref_i  (ref_i),
    .tap_o  (tap)
  );

  assign match     = ~(tap ^ {(MAX_DELAY + 1){dly_i}});
  assign cand_next = cand_q & match;

  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path can infer a latch.
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;

    if (start_i) begin
      state_d = ACQ;
      cand_d  = '1;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ACQ: begin
          if (cand_next == '0) begin
            state_d = FAIL;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            cand_d = cand_next;
            if (is_onehot(32'(cand_next))) begin
              state_d = LOCKED;
              delay_d = DLY_W'(onehot_idx(32'(cand_next)));
            end
          end else begin
            cand_d = cand_next;
            cnt_d  = cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          if (!match[delay_q]) begin
`ifdef DELAY_EST_RELOCK_EN
            state_d = ACQ;
            cand_d  = '1;
            cnt_d   = '0;
`else
            state_d = FAIL;
`endif
          end
        end
        default: ;  // IDLE and FAIL wait for start_i
      endcase
    end

    if (state_d != LOCKED) delay_d = '0;
    valid_d = (state_d == LOCKED);
    busy_d  = (state_d == ACQ);
    err_d   = (state_d == FAIL);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cand_q  <= '1;
      cnt_q   <= '0;
      delay_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign delay_o = delay_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_delay_estimator.sv
// Randomized bench for delay_estimator against a consistency-search reference model.
module tb_delay_estimator;

  localparam int MAXD = 15;
  localparam int LCNT = 32;

  logic       clk_i   = 1'b0;
  logic       rst_ni  = 1'b0;
  logic       ref_i   = 1'b0;
  logic       dly_i   = 1'b0;
  logic       start_i = 1'b0;
  logic [3:0] delay_o;
  logic       valid_o;
  logic       busy_o;
  logic       err_o;

  delay_estimator dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .ref_i   (ref_i),
    .dly_i   (dly_i),
    .start_i (start_i),
    .delay_o (delay_o),
    .valid_o (valid_o),
    .busy_o  (busy_o),
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: logs every sampled (ref, dly) pair since reset and, while acquiring,
  // searches for the delays consistent with all pairs seen since acquisition started.
  typedef enum int {M_IDLE, M_ACQ, M_LOCK, M_FAIL} mstate_e;
  mstate_e m_state = M_IDLE;
  int      m_delay = 0;
  int      acq_start = 0;
  bit      ref_log[$];
  bit      dly_log[$];
  int      chan_d = 0;
  bit      chan_inv = 1'b0;
  string   scen = "reset";

  function automatic bit ref_at(input int m);
    if (m < 0) return 1'b0;
    return ref_log[m];
  endfunction

  function automatic int consistent_taps(output int last_k);
    int cnt = 0;
    last_k = 0;
    for (int k = 0; k <= MAXD; k++) begin
      bit ok = 1'b1;
      for (int n = acq_start; n < ref_log.size(); n++)
        if (dly_log[n] != ref_at(n - k)) ok = 1'b0;
      if (ok) begin
        cnt++;
        last_k = k;
      end
    end
    return cnt;
  endfunction

  function automatic void model_reset();
    m_state = M_IDLE;
    m_delay = 0;
    ref_log.delete();
    dly_log.delete();
  endfunction

  function automatic void model_update(input bit r, input bit d, input bit s);
    int n, cnt, k;
    ref_log.push_back(r);
    dly_log.push_back(d);
    n = ref_log.size() - 1;
    if (s) begin
      m_state   = M_ACQ;
      acq_start = n + 1;
    end else begin
      case (m_state)
        M_ACQ: begin
          cnt = consistent_taps(k);
          if (cnt == 0) m_state = M_FAIL;
          else if (((n - acq_start) % LCNT) == LCNT - 1 && cnt == 1) begin
            m_state = M_LOCK;
            m_delay = k;
          end
        end
        M_LOCK: begin
          if (d != ref_at(n - m_delay)) begin
`ifdef DELAY_EST_RELOCK_EN
            m_state   = M_ACQ;
            acq_start = n + 1;
`else
            m_state = M_FAIL;
`endif
          end
        end
        default: ;
      endcase
    end
  endfunction

  function automatic bit channel_out(input bit r);
    int n = ref_log.size();
    bit v = (chan_d == 0) ? r : ref_at(n - chan_d);
    return v ^ chan_inv;
  endfunction

  task automatic compare();
    check({scen, ":valid"}, valid_o, int'(m_state == M_LOCK));
    check({scen, ":busy"},  busy_o,  int'(m_state == M_ACQ));
    check({scen, ":err"},   err_o,   int'(m_state == M_FAIL));
    if (m_state != M_ACQ)
      check({scen, ":delay"}, delay_o, (m_state == M_LOCK) ? m_delay : 0);
  endtask

  // One clock cycle: drive at the falling edge, model at the rising edge, compare at the next fall.
  task automatic step(input bit r, input bit s);
    ref_i   = r;
    start_i = s;
    dly_i   = channel_out(r);
    @(posedge clk_i);
    model_update(r, dly_i, s);
    @(negedge clk_i);
    compare();
  endtask

  task automatic run_rand(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic run_until_lock(input string tag, input int bound);
    for (int i = 0; i < bound && m_state != M_LOCK; i++) step(1'($urandom_range(0, 1)), 1'b0);
    check(tag, valid_o, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ":valid"}, valid_o, 0);
    check({tag, ":busy"},  busy_o,  0);
    check({tag, ":err"},   err_o,   0);
    check({tag, ":delay"}, delay_o, 0);
  endtask

  // Asynchronous reset asserted between clock edges; called at a falling edge.
  task automatic do_reset(input string tag);
    #2 rst_ni = 1'b0;
    start_i = 1'b0;
    #1 check_outputs_zero({tag, "_async"});
    model_reset();
    repeat (2) @(negedge clk_i);
    check_outputs_zero({tag, "_held"});
    rst_ni = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk_i);
    check_outputs_zero("por");
    rst_ni = 1'b1;

    // 1: delay 0, lock latency from the start pulse
    scen = "d0";
    chan_d = 0;
    run_rand(20);
    step(1'($urandom_range(0, 1)), 1'b1);
    repeat (31) step(1'($urandom_range(0, 1)), 1'b0);
    check("d0_pre_valid", valid_o, 0);
    check("d0_pre_busy", busy_o, 1);
    step(1'($urandom_range(0, 1)), 1'b0);
    check("d0_valid", valid_o, 1);
    check("d0_delay", delay_o, 0);
    check("d0_busy", busy_o, 0);
    run_rand(10);

    // 2: delay 15, 20 cycles after reset
    scen = "d15";
    do_reset("d15_rst");
    chan_d = 15;
    run_rand(20);
    step(1'($urandom_range(0, 1)), 1'b1);
    run_until_lock("d15_lock", 200);
    check("d15_delay", delay_o, 15);
    check("d15_err", err_o, 0);

    // 3: constant stream is ambiguous, random stream then resolves it
    scen = "const";
    do_reset("const_rst");
    chan_d = 5;
    repeat (20) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (96) step(1'b1, 1'b0);
    check("const_busy", busy_o, 1);
    check("const_valid", valid_o, 0);
    run_until_lock("const_lock", 200);
    check("const_delay", delay_o, 5);

    // 4: inverted channel, no tap is consistent
    scen = "inv";
    chan_d = 3;
    chan_inv = 1'b1;
    step(1'($urandom_range(0, 1)), 1'b1);
    repeat (LCNT) step(1'($urandom_range(0, 1)), 1'b0);
    check("inv_err", err_o, 1);
    check("inv_valid", valid_o, 0);
    run_rand(5);
    chan_inv = 1'b0;
    step(1'($urandom_range(0, 1)), 1'b1);
    check("inv_clear_err", err_o, 0);
    check("inv_clear_busy", busy_o, 1);

    // 5: locked at 7, channel changes to 3
    scen = "switch";
    chan_d = 7;
    step(1'($urandom_range(0, 1)), 1'b1);
    run_until_lock("sw_lock7", 200);
    check("sw_delay7", delay_o, 7);
    chan_d = 3;
    for (int i = 0; i < 60 && m_state == M_LOCK; i++) step(1'($urandom_range(0, 1)), 1'b0);
`ifdef DELAY_EST_RELOCK_EN
    check("sw_relock_busy", busy_o, 1);
    check("sw_relock_err", err_o, 0);
    run_until_lock("sw_lock3", 200);
    check("sw_delay3", delay_o, 3);
`else
    check("sw_err", err_o, 1);
    check("sw_valid", valid_o, 0);
    run_rand(5);
`endif

    // 6: reset mid-acquisition and mid-lock
    scen = "rst";
    chan_d = 9;
    step(1'($urandom_range(0, 1)), 1'b1);
    run_rand(10);
    do_reset("rst_acq");
    run_rand(3);
    step(1'($urandom_range(0, 1)), 1'b1);
    run_until_lock("rst_relock", 200);
    check("rst_delay", delay_o, 9);
    run_rand(5);
    do_reset("rst_lock");
    run_rand(3);
    step(1'($urandom_range(0, 1)), 1'b1);
    run_until_lock("rst_lock_again", 200);
    check("rst_delay2", delay_o, 9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
